// File: rtl/parking_gate_scheduler.sv
// Shares one barrier gate and password checker between N_ENTRY entrance lanes
// and one exit lane, tracking lot occupancy and locking out repeated bad codes.
module parking_gate_scheduler #(
  parameter int           N_ENTRY      = 2,
  parameter int           CAPACITY     = 8,
  parameter logic [7:0]   PASSWORD     = 8'h0E,
  parameter int           PWD_TIMEOUT  = 20,
  parameter int           OPEN_TIMEOUT = 30,
  parameter int           MAX_TRIES    = 3,
  parameter int           LOCK_CYCLES  = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_ENTRY-1:0] entry_req,
  input  logic               exit_req,
  input  logic               pwd_valid,
  input  logic [7:0]         pwd,
  input  logic               car_passed,
  output logic [N_ENTRY-1:0] entry_grant,
  output logic               exit_grant,
  output logic               gate_open,
  output logic               green_led,
  output logic               red_led,
  output logic               full,
  output logic [7:0]         occupancy
);

  localparam int T_MAX0 = (PWD_TIMEOUT > OPEN_TIMEOUT) ? PWD_TIMEOUT : OPEN_TIMEOUT;
  localparam int T_MAX  = (T_MAX0 > LOCK_CYCLES) ? T_MAX0 : LOCK_CYCLES;
  localparam int TW     = $clog2(T_MAX + 1);
  localparam int PW     = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
  localparam int CW     = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PASS,
    OPEN_IN,
    OPEN_OUT,
    LOCKOUT
  } state_t;

  state_t             state;
  logic [TW-1:0]      timer;
  logic [CW-1:0]      tries;
  logic [CW-1:0]      tries_next;
  logic [PW-1:0]      rr_ptr;
  logic               pick_found;
  logic [PW-1:0]      pick_idx;
  logic [N_ENTRY-1:0] pick_onehot;
  logic [PW:0]        lane_sum;
  logic [PW-1:0]      lane_idx;

  assign full       = (occupancy == 8'(CAPACITY));
  assign tries_next = tries + CW'(1);

  // Round-robin search: first requesting lane at or after the pointer, wrapping.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    lane_sum    = '0;
    lane_idx    = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      lane_sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (lane_sum >= (PW+1)'(N_ENTRY))
        lane_sum = lane_sum - (PW+1)'(N_ENTRY);
      lane_idx = lane_sum[PW-1:0];
      if (!pick_found && entry_req[lane_idx]) begin
        pick_found            = 1'b1;
        pick_idx              = lane_idx;
        pick_onehot[lane_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      tries       <= '0;
      rr_ptr      <= '0;
      entry_grant <= '0;
      exit_grant  <= 1'b0;
      gate_open   <= 1'b0;
      green_led   <= 1'b0;
      red_led     <= 1'b0;
      occupancy   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (exit_req && occupancy != 8'd0) begin
            state      <= OPEN_OUT;
            exit_grant <= 1'b1;
            gate_open  <= 1'b1;
            green_led  <= 1'b1;
          end else if (pick_found && !full) begin
            state       <= WAIT_PASS;
            entry_grant <= pick_onehot;
            rr_ptr      <= (pick_idx == PW'(N_ENTRY - 1)) ? '0 : pick_idx + PW'(1);
          end
        end

        // A strobe in the timeout cycle still counts as an attempt.
        WAIT_PASS: begin
          if (pwd_valid && pwd == PASSWORD) begin
            state     <= OPEN_IN;
            timer     <= '0;
            tries     <= '0;
            red_led   <= 1'b0;
            gate_open <= 1'b1;
            green_led <= 1'b1;
          end else if (pwd_valid) begin
            tries   <= tries_next;
            red_led <= 1'b1;
            timer   <= '0;
            if (tries_next == CW'(MAX_TRIES)) begin
              state       <= LOCKOUT;
              entry_grant <= '0;
            end
          end else if ((entry_req & entry_grant) == '0) begin
            state       <= IDLE;
            entry_grant <= '0;
            timer       <= '0;
          end else if (timer == TW'(PWD_TIMEOUT - 1)) begin
            state       <= IDLE;
            entry_grant <= '0;
            red_led     <= 1'b0;
            timer       <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        OPEN_IN, OPEN_OUT: begin
          if (car_passed || timer == TW'(OPEN_TIMEOUT - 1)) begin
            state       <= IDLE;
            timer       <= '0;
            entry_grant <= '0;
            exit_grant  <= 1'b0;
            gate_open   <= 1'b0;
            green_led   <= 1'b0;
            if (car_passed) begin
              if (state == OPEN_IN && occupancy < 8'(CAPACITY))
                occupancy <= occupancy + 8'd1;
              else if (state == OPEN_OUT && occupancy != 8'd0)
                occupancy <= occupancy - 8'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        LOCKOUT: begin
          entry_grant <= '0;
          exit_grant  <= 1'b0;
          gate_open   <= 1'b0;
          green_led   <= 1'b0;
          if (timer == TW'(LOCK_CYCLES - 1)) begin
            state   <= IDLE;
            timer   <= '0;
            tries   <= '0;
            red_led <= 1'b0;
          end else begin
            red_led <= 1'b1;
            timer   <= timer + TW'(1);
          end
        end

        default: begin
          state       <= IDLE;
          timer       <= '0;
          entry_grant <= '0;
          exit_grant  <= 1'b0;
          gate_open   <= 1'b0;
          green_led   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed bench for parking_gate_scheduler: entry/exit transactions, round-robin,
// lockout, capacity limit, gate and password timeouts, mid-transaction reset.
module tb_parking_gate_scheduler;

  logic       clk;
  logic       rst_n;
  logic [1:0] entry_req;
  logic       exit_req;
  logic       pwd_valid;
  logic [7:0] pwd;
  logic       car_passed;
  logic [1:0] entry_grant;
  logic       exit_grant;
  logic       gate_open;
  logic       green_led;
  logic       red_led;
  logic       full;
  logic [7:0] occupancy;

  int total = 0;
  int bad   = 0;

  parking_gate_scheduler #(
    .N_ENTRY(2), .CAPACITY(8), .PASSWORD(8'h0E), .PWD_TIMEOUT(20),
    .OPEN_TIMEOUT(30), .MAX_TRIES(3), .LOCK_CYCLES(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
    .pwd_valid(pwd_valid), .pwd(pwd), .car_passed(car_passed),
    .entry_grant(entry_grant), .exit_grant(exit_grant), .gate_open(gate_open),
    .green_led(green_led), .red_led(red_led), .full(full), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive inputs, then let one rising edge pass and return at the falling edge.
  task automatic applyStimulus(input logic [1:0] er, input logic ex, input logic pv,
                               input logic [7:0] p, input logic cp);
    entry_req  = er;
    exit_req   = ex;
    pwd_valid  = pv;
    pwd        = p;
    car_passed = cp;
    @(negedge clk);
  endtask

  task automatic enterCar(input logic [1:0] req, input logic [1:0] exp_grant, input int exp_occ);
    applyStimulus(req, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("entry_grant", 32'(entry_grant), 32'(exp_grant));
    checkOutput("gate_shut_wait", 32'(gate_open), 32'd0);
    applyStimulus(req, 1'b0, 1'b1, 8'h0E, 1'b0);
    checkOutput("gate_open_in", 32'(gate_open), 32'd1);
    checkOutput("green_in", 32'(green_led), 32'd1);
    checkOutput("grant_held", 32'(entry_grant), 32'(exp_grant));
    applyStimulus(req, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("occ_in", 32'(occupancy), 32'(exp_occ));
    checkOutput("gate_shut_in", 32'(gate_open), 32'd0);
    checkOutput("grant_clear", 32'(entry_grant), 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rst_grant", 32'(entry_grant), 32'd0);
    checkOutput("rst_exit", 32'(exit_grant), 32'd0);
    checkOutput("rst_gate", 32'(gate_open), 32'd0);
    checkOutput("rst_leds", 32'({green_led, red_led}), 32'd0);
    checkOutput("rst_occ", 32'(occupancy), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;

    // Single entry on lane 0
    enterCar(2'b01, 2'b01, 1);

    // Reset clears occupancy and the round-robin pointer
    rst_n = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rst_occ_clear", 32'(occupancy), 32'd0);
    rst_n = 1'b1;

    // Both lanes requesting: lane 0 then lane 1
    enterCar(2'b11, 2'b01, 1);
    enterCar(2'b11, 2'b10, 2);
    enterCar(2'b01, 2'b01, 3);

    // Exit beats a simultaneous entry request
    applyStimulus(2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("exit_prio", 32'(exit_grant), 32'd1);
    checkOutput("exit_no_entry", 32'(entry_grant), 32'd0);
    checkOutput("exit_gate", 32'(gate_open), 32'd1);
    applyStimulus(2'b01, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("occ_out", 32'(occupancy), 32'd2);
    checkOutput("exit_clear", 32'(exit_grant), 32'd0);
    enterCar(2'b01, 2'b01, 3);

    // Three wrong codes lead to lockout
    applyStimulus(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("lk_grant", 32'(entry_grant), 32'd1);
    applyStimulus(2'b01, 1'b0, 1'b1, 8'h0D, 1'b0);
    checkOutput("wrong1_red", 32'(red_led), 32'd1);
    checkOutput("wrong1_grant", 32'(entry_grant), 32'd1);
    applyStimulus(2'b01, 1'b0, 1'b1, 8'h0F, 1'b0);
    checkOutput("wrong2_red", 32'(red_led), 32'd1);
    checkOutput("wrong2_gate", 32'(gate_open), 32'd0);
    applyStimulus(2'b01, 1'b0, 1'b1, 8'h0D, 1'b0);
    checkOutput("lock_red", 32'(red_led), 32'd1);
    checkOutput("lock_grant", 32'(entry_grant), 32'd0);
    checkOutput("lock_gate", 32'(gate_open), 32'd0);
    for (int i = 0; i < 39; i++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput("lock_hold", 32'({red_led, gate_open, exit_grant, entry_grant}), 32'b10000);
    end
    applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("unlock_red", 32'(red_led), 32'd0);
    checkOutput("unlock_grants", 32'({exit_grant, entry_grant}), 32'd0);
    checkOutput("unlock_occ", 32'(occupancy), 32'd3);

    // Fill the lot
    for (int n = 4; n <= 8; n++) enterCar(2'b01, 2'b01, n);
    checkOutput("full_set", 32'(full), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("full_no_grant", 32'(entry_grant), 32'd0);
    end
    applyStimulus(2'b00, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("full_exit_grant", 32'(exit_grant), 32'd1);
    applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("full_exit_occ", 32'(occupancy), 32'd7);
    checkOutput("full_clear", 32'(full), 32'd0);

    // Gate open with no car: closes after 30 cycles, occupancy unchanged
    applyStimulus(2'b00, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("to_gate_open", 32'(gate_open), 32'd1);
    for (int i = 0; i < 29; i++) applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("to_gate_still", 32'(gate_open), 32'd1);
    applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("to_gate_shut", 32'(gate_open), 32'd0);
    checkOutput("to_exit_clear", 32'(exit_grant), 32'd0);
    checkOutput("to_occ", 32'(occupancy), 32'd7);

    // Password timeout after 20 cycles in WAIT_PASS
    applyStimulus(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("pto_grant", 32'(entry_grant), 32'd1);
    for (int i = 0; i < 19; i++) applyStimulus(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("pto_still", 32'(entry_grant), 32'd1);
    applyStimulus(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("pto_drop", 32'(entry_grant), 32'd0);
    applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset in the middle of WAIT_PASS
    applyStimulus(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("mid_grant", 32'(entry_grant), 32'd1);
    applyStimulus(2'b01, 1'b0, 1'b1, 8'h0D, 1'b0);
    checkOutput("mid_red", 32'(red_led), 32'd1);
    rst_n = 1'b0;
    applyStimulus(2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("mid_rst_grant", 32'(entry_grant), 32'd0);
    checkOutput("mid_rst_red", 32'(red_led), 32'd0);
    checkOutput("mid_rst_occ", 32'(occupancy), 32'd0);
    checkOutput("mid_rst_misc", 32'({exit_grant, gate_open, green_led, full}), 32'd0);
    rst_n = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
